regfile_wdec_dual: RTL and testbench

- Parametrised write-enable decoder for the register file. Generalises the combinational 4-to-16 destination decoder.
- Two write ports (A = older instruction, B = younger instruction).
- Registered one-hot outputs with a downstream stall. A one-entry skid buffer holds requests while stalled.
- Same-address conflicts resolve to the younger write. Optional hard-wired-zero register suppression.
- Sits between writeback and the register file write-enable inputs.

---
 rtl/regfile_wdec_dual.sv | 93 +++++++++
 tb/tb_regfile_wdec_dual.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wdec_dual.sv
// Register-file write-enable decoder for two writeback ports.
// Older port A and younger port B decode to one-hot enables. When both
// ports target the same register, the younger write (B) wins. A one-entry
// skid buffer absorbs one request pair while the register file stalls.
module regfile_wdec_dual #(
  parameter int unsigned ADDR_W   = 4,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrA_valid,
  input  logic [ADDR_W-1:0]        wrA_addr,
  input  logic                     wrB_valid,
  input  logic [ADDR_W-1:0]        wrB_addr,
  output logic                     in_ready,
  input  logic                     stall,
  output logic [(2**ADDR_W)-1:0]   decOutA,
  output logic [(2**ADDR_W)-1:0]   decOutB,
  output logic [(2**ADDR_W)-1:0]   decOut,
  output logic                     out_valid,
  output logic                     conflict
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef struct packed {
    logic [DEPTH-1:0] ena;
    logic [DEPTH-1:0] enb;
    logic             conflict;
  } dec_t;

  dec_t dec_c;
  dec_t pend_q;
  dec_t out_q;
  logic pend_valid_q;
  logic out_valid_q;
  logic [DEPTH-1:0] decout_q;
  logic accept_c;

  // A pair is taken only when the skid buffer is empty.
  assign accept_c = !pend_valid_q && (wrA_valid || wrB_valid);

  // Decode the incoming pair: zero-register suppression first, then the
  // same-address rule, which drops the older write.
  always_comb begin
    dec_c = '0;
    if (wrA_valid && !(ZERO_REG && (wrA_addr == '0)))
      dec_c.ena = DEPTH'(1) << wrA_addr;
    if (wrB_valid && !(ZERO_REG && (wrB_addr == '0)))
      dec_c.enb = DEPTH'(1) << wrB_addr;
    if (wrA_valid && wrB_valid && (wrA_addr == wrB_addr)) begin
      dec_c.ena      = '0;
      dec_c.conflict = 1'b1;
    end
  end

  // Output stage and skid buffer. Pending always drains ahead of new input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      decout_q     <= '0;
    end else if (!stall) begin
      if (pend_valid_q) begin
        out_q        <= pend_q;
        out_valid_q  <= 1'b1;
        decout_q     <= pend_q.ena | pend_q.enb;
        pend_valid_q <= 1'b0;
      end else if (accept_c) begin
        out_q       <= dec_c;
        out_valid_q <= 1'b1;
        decout_q    <= dec_c.ena | dec_c.enb;
      end else begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
        decout_q    <= '0;
      end
    end else if (accept_c) begin
      pend_q       <= dec_c;
      pend_valid_q <= 1'b1;
    end
  end

  assign in_ready  = !pend_valid_q;
  assign decOutA   = out_q.ena;
  assign decOutB   = out_q.enb;
  assign decOut    = decout_q;
  assign conflict  = out_q.conflict;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_regfile_wdec_dual.sv
// Directed bench for regfile_wdec_dual: one instance with zero-register
// suppression, one without, both driven by the same inputs.
module tb_regfile_wdec_dual;

  logic        clk;
  logic        reset;
  logic        wrA_valid;
  logic [3:0]  wrA_addr;
  logic        wrB_valid;
  logic [3:0]  wrB_addr;
  logic        stall;

  logic        rdy0, ov0, cf0;
  logic [15:0] da0, db0, d0;
  logic        rdy1, ov1, cf1;
  logic [15:0] da1, db1, d1;

  int total = 0;
  int bad   = 0;

  regfile_wdec_dual #(.ADDR_W(4), .ZERO_REG(1'b1)) u0 (
    .clk(clk), .reset(reset),
    .wrA_valid(wrA_valid), .wrA_addr(wrA_addr),
    .wrB_valid(wrB_valid), .wrB_addr(wrB_addr),
    .in_ready(rdy0), .stall(stall),
    .decOutA(da0), .decOutB(db0), .decOut(d0),
    .out_valid(ov0), .conflict(cf0)
  );

  regfile_wdec_dual #(.ADDR_W(4), .ZERO_REG(1'b0)) u1 (
    .clk(clk), .reset(reset),
    .wrA_valid(wrA_valid), .wrA_addr(wrA_addr),
    .wrB_valid(wrB_valid), .wrB_addr(wrB_addr),
    .in_ready(rdy1), .stall(stall),
    .decOutA(da1), .decOutB(db1), .decOut(d1),
    .out_valid(ov1), .conflict(cf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [3:0] aa,
                       input logic bv, input logic [3:0] ba);
    wrA_valid = av; wrA_addr = aa;
    wrB_valid = bv; wrB_addr = ba;
  endtask

  // Output invariants: each port at most one-hot, ports never overlap.
  always @(negedge clk) begin
    if (reset) begin
      chk("inv_onehot_a", 16'($onehot0(da0)), 16'd1);
      chk("inv_onehot_b", 16'($onehot0(db0)), 16'd1);
      chk("inv_disjoint", da0 & db0, 16'h0000);
    end
  end

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 4'd0);

    // Reset state
    #12;
    chk("rst_decA", da0, 16'h0000);
    chk("rst_decB", db0, 16'h0000);
    chk("rst_dec", d0, 16'h0000);
    chk("rst_ov", 16'(ov0), 16'd0);
    chk("rst_cf", 16'(cf0), 16'd0);
    reset = 1'b1;
    #1;
    chk("rst_rdy", 16'(rdy0), 16'd1);

    // Single write on A
    drive(1'b1, 4'd5, 1'b0, 4'd0);
    step();
    chk("t1_decA", da0, 16'h0020);
    chk("t1_decB", db0, 16'h0000);
    chk("t1_dec", d0, 16'h0020);
    chk("t1_ov", 16'(ov0), 16'd1);
    chk("t1_cf", 16'(cf0), 16'd0);
    drive(1'b0, 4'd0, 1'b0, 4'd0);
    step();
    chk("t1_idle_dec", d0, 16'h0000);
    chk("t1_idle_ov", 16'(ov0), 16'd0);

    // Dual distinct writes
    drive(1'b1, 4'd3, 1'b1, 4'd15);
    step();
    chk("t2_decA", da0, 16'h0008);
    chk("t2_decB", db0, 16'h8000);
    chk("t2_dec", d0, 16'h8008);
    chk("t2_cf", 16'(cf0), 16'd0);

    // Same-address conflict: younger wins
    drive(1'b1, 4'd7, 1'b1, 4'd7);
    step();
    chk("t3_decA", da0, 16'h0000);
    chk("t3_decB", db0, 16'h0080);
    chk("t3_dec", d0, 16'h0080);
    chk("t3_cf", 16'(cf0), 16'd1);

    // Zero register, with and without suppression
    drive(1'b1, 4'd0, 1'b1, 4'd2);
    step();
    chk("t4_z1_decA", da0, 16'h0000);
    chk("t4_z1_decB", db0, 16'h0004);
    chk("t4_z1_ov", 16'(ov0), 16'd1);
    chk("t4_z0_decA", da1, 16'h0001);
    chk("t4_z0_decB", db1, 16'h0004);
    chk("t4_z0_dec", d1, 16'h0005);
    drive(1'b1, 4'd0, 1'b1, 4'd0);
    step();
    chk("t4_zz1_dec", d0, 16'h0000);
    chk("t4_zz1_ov", 16'(ov0), 16'd1);
    chk("t4_zz1_cf", 16'(cf0), 16'd1);
    chk("t4_zz0_decA", da1, 16'h0000);
    chk("t4_zz0_decB", db1, 16'h0001);
    chk("t4_zz0_cf", 16'(cf1), 16'd1);

    // Stall and skid buffer
    drive(1'b1, 4'd1, 1'b0, 4'd0);
    step();
    chk("t5_p1_decA", da0, 16'h0002);
    stall = 1'b1;
    drive(1'b0, 4'd0, 1'b1, 4'd4);
    step();
    chk("t5_p2_rdy", 16'(rdy0), 16'd0);
    chk("t5_p2_hold", da0, 16'h0002);
    chk("t5_p2_ov", 16'(ov0), 16'd1);
    drive(1'b1, 4'd9, 1'b0, 4'd0);
    step();
    chk("t5_p3_hold", d0, 16'h0002);
    chk("t5_p3_rdy", 16'(rdy0), 16'd0);
    stall = 1'b0;
    step();
    chk("t5_drain_decB", db0, 16'h0010);
    chk("t5_drain_decA", da0, 16'h0000);
    chk("t5_drain_rdy", 16'(rdy0), 16'd1);
    step();
    chk("t5_p3_decA", da0, 16'h0200);
    chk("t5_p3_decB", db0, 16'h0000);
    drive(1'b0, 4'd0, 1'b0, 4'd0);
    step();
    chk("t5_idle_ov", 16'(ov0), 16'd0);

    // Full hold, then asynchronous reset mid-cycle
    drive(1'b1, 4'd6, 1'b0, 4'd0);
    step();
    stall = 1'b1;
    drive(1'b0, 4'd0, 1'b1, 4'd11);
    step();
    drive(1'b0, 4'd0, 1'b0, 4'd0);
    step();
    step();
    chk("t6_hold_decA", da0, 16'h0040);
    chk("t6_hold_rdy", 16'(rdy0), 16'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_dec", d0, 16'h0000);
    chk("t6_rst_decA", da0, 16'h0000);
    chk("t6_rst_ov", 16'(ov0), 16'd0);
    chk("t6_rst_rdy", 16'(rdy0), 16'd1);
    #3;
    reset = 1'b1;
    stall = 1'b0;
    step();
    chk("t6_post_ov", 16'(ov0), 16'd0);
    chk("t6_post_rdy", 16'(rdy0), 16'd1);
    chk("t6_post_dec", d0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
